// File: rtl/bidsn_auction_if.sv
// Bus bundle for the bidsn_auction engine: controller ops, bidder strobes,
// and round results. The master modport drives stimulus and the slave
// modport is the engine side.
interface bidsn_auction_if #(
  parameter int NUM_BIDDERS = 4,
  parameter int VAL_W       = 16
);
  localparam int SEL_W = $clog2(NUM_BIDDERS);

  logic [2:0]                   C_op;
  logic [VAL_W-1:0]             C_data;
  logic [SEL_W-1:0]             C_sel;
  logic                         C_start;
  logic [NUM_BIDDERS-1:0]       bid_valid;
  logic [NUM_BIDDERS*VAL_W-1:0] bid_val;
  logic [NUM_BIDDERS-1:0]       bid_ack;
  logic [NUM_BIDDERS-1:0]       bid_rej;
  logic                         ready;
  logic [2:0]                   err;
  logic                         round_over;
  logic [VAL_W-1:0]             max_bid;
  logic [NUM_BIDDERS-1:0]       win;
  logic [NUM_BIDDERS*8-1:0]     win_count;

  modport master (
    output C_op, C_data, C_sel, C_start, bid_valid, bid_val,
    input  bid_ack, bid_rej, ready, err, round_over, max_bid, win, win_count
  );

  modport slave (
    input  C_op, C_data, C_sel, C_start, bid_valid, bid_val,
    output bid_ack, bid_rej, ready, err, round_over, max_bid, win, win_count
  );
endinterface

// File: rtl/bidsn_auction.sv
// bidsn_auction: parametrised sealed-round auction engine.
// A controller configures balances, bid cost, enable mask and round timeout
// while unlocked, locks the engine with a key, then runs timed rounds that
// resolve to one winner (highest bid, ties to the lowest index).
// Optional macro BIDS_STATS_EN adds saturating 8-bit per-bidder win counters
// on win_count; without it win_count is tied to zero.

// Per-bidder slice: holds the balance, qualifies the bid, optional win stats.
module bidsn_auction_lane #(
  parameter int VAL_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_active,
  input  logic             i_bid_valid,
  input  logic             i_mask,
  input  logic [VAL_W-1:0] i_bid_val,
  input  logic [VAL_W-1:0] i_cur_max,
  input  logic [VAL_W-1:0] i_cost,
  input  logic             i_load,
  input  logic [VAL_W-1:0] i_load_val,
  input  logic             i_win,
  input  logic [VAL_W-1:0] i_win_amt,
  output logic             o_qual,
  output logic [7:0]       o_win_cnt
);
  logic [VAL_W-1:0] r_bal;
  logic [VAL_W:0]   w_need;

  // Funding check is one bit wider so bid+cost can never wrap.
  assign w_need = {1'b0, i_bid_val} + {1'b0, i_cost};
  assign o_qual = i_active & i_bid_valid & i_mask & (i_bid_val > i_cur_max) &
                  ({1'b0, r_bal} >= w_need);

  // Balance: loaded while unlocked, charged cost per qualifying bid, charged
  // the winning bid at round end. These never coincide (different states).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_bal <= '0;
    else if (i_load) r_bal <= i_load_val;
    else if (o_qual) r_bal <= r_bal - i_cost;
    else if (i_win)  r_bal <= r_bal - i_win_amt;
  end

`ifdef BIDS_STATS_EN
  logic [7:0] r_win_cnt;

  // Saturating win counter, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_win_cnt <= '0;
    else if (i_win && r_win_cnt != 8'hFF) r_win_cnt <= r_win_cnt + 8'd1;
  end

  assign o_win_cnt = r_win_cnt;
`else
  assign o_win_cnt = '0;
`endif
endmodule

module bidsn_auction #(
  parameter int          NUM_BIDDERS     = 4,
  parameter int          VAL_W           = 16,
  parameter int          TIMER_W         = 8,
  parameter int unsigned DEFAULT_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  bidsn_auction_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_BIDDERS);
  // A zero timeout would never expire; it behaves as one cycle instead.
  localparam logic [TIMER_W-1:0] DEF_TMO =
    (DEFAULT_TIMEOUT == 0) ? TIMER_W'(1) : TIMER_W'(DEFAULT_TIMEOUT);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_UNLK  = 3'd1;
  localparam logic [2:0] OP_LOCK  = 3'd2;
  localparam logic [2:0] OP_BAL   = 3'd3;
  localparam logic [2:0] OP_TMR   = 3'd4;
  localparam logic [2:0] OP_COST  = 3'd5;
  localparam logic [2:0] OP_MASK  = 3'd6;

  localparam logic [2:0] E_NONE   = 3'd0;
  localparam logic [2:0] E_KEY    = 3'd1;
  localparam logic [2:0] E_LOCKED = 3'd2;
  localparam logic [2:0] E_NLOCK  = 3'd3;
  localparam logic [2:0] E_OP     = 3'd4;

  typedef enum logic [1:0] {S_UNLOCKED, S_LOCKED, S_ACTIVE, S_END} state_t;

  state_t                             r_state;
  logic [VAL_W-1:0]                   r_key;
  logic [VAL_W-1:0]                   r_cost;
  logic [NUM_BIDDERS-1:0]             r_mask;
  logic [TIMER_W-1:0]                 r_timeout;
  logic [TIMER_W-1:0]                 r_timer;
  logic                               r_start_d;
  logic [VAL_W-1:0]                   r_cur_max;
  logic [NUM_BIDDERS-1:0]             r_lead;
  logic [2:0]                         r_err;
  logic                               r_ready;
  logic                               r_round_over;
  logic [VAL_W-1:0]                   r_max_bid;
  logic [NUM_BIDDERS-1:0]             r_win;
  logic [NUM_BIDDERS-1:0]             r_ack;
  logic [NUM_BIDDERS-1:0]             r_rej;

  logic [NUM_BIDDERS-1:0][VAL_W-1:0]  w_val;
  logic [NUM_BIDDERS-1:0][7:0]        w_wcnt;
  logic [NUM_BIDDERS-1:0]             w_qual;
  logic [NUM_BIDDERS-1:0]             w_load;
  logic [NUM_BIDDERS-1:0]             w_lead_oh;
  logic [VAL_W-1:0]                   w_best;
  logic                               w_new;
  logic                               w_rise;
  logic                               w_active;
  logic                               w_sel_ok;
  logic [TIMER_W-1:0]                 w_tmr_in;

  assign w_val    = bus.bid_val;
  assign w_rise   = bus.C_start & ~r_start_d;
  assign w_active = (r_state == S_ACTIVE);
  assign w_sel_ok = (int'(bus.C_sel) < NUM_BIDDERS);
  assign w_tmr_in = (bus.C_data[TIMER_W-1:0] == '0) ? TIMER_W'(1)
                                                     : bus.C_data[TIMER_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BIDDERS; gi++) begin : g_lane
      assign w_load[gi] = (r_state == S_UNLOCKED) && (bus.C_op == OP_BAL) &&
                          (int'(bus.C_sel) == gi);
      bidsn_auction_lane #(.VAL_W(VAL_W)) u_lane (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_active    (w_active),
        .i_bid_valid (bus.bid_valid[gi]),
        .i_mask      (r_mask[gi]),
        .i_bid_val   (w_val[gi]),
        .i_cur_max   (r_cur_max),
        .i_cost      (r_cost),
        .i_load      (w_load[gi]),
        .i_load_val  (bus.C_data),
        .i_win       ((r_state == S_END) && r_lead[gi]),
        .i_win_amt   (r_cur_max),
        .o_qual      (w_qual[gi]),
        .o_win_cnt   (w_wcnt[gi])
      );
    end
  endgenerate

  // Pick this cycle's leader among qualifying bids; strict compare keeps the
  // lowest index on ties.
  always_comb begin
    w_best    = r_cur_max;
    w_lead_oh = '0;
    w_new     = 1'b0;
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (w_qual[i] && (w_val[i] > w_best)) begin
        w_best    = w_val[i];
        w_lead_oh = '0;
        w_lead_oh[i] = 1'b1;
        w_new     = 1'b1;
      end
    end
  end

  // Control FSM with all externally visible outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_UNLOCKED;
      r_key        <= '0;
      r_cost       <= VAL_W'(1);
      r_mask       <= '1;
      r_timeout    <= DEF_TMO;
      r_timer      <= '0;
      r_start_d    <= 1'b0;
      r_cur_max    <= '0;
      r_lead       <= '0;
      r_err        <= E_NONE;
      r_ready      <= 1'b1;
      r_round_over <= 1'b0;
      r_max_bid    <= '0;
      r_win        <= '0;
      r_ack        <= '0;
      r_rej        <= '0;
    end else begin
      r_start_d    <= bus.C_start;
      r_round_over <= 1'b0;
      r_ack        <= '0;
      r_rej        <= '0;
      case (r_state)
        S_UNLOCKED: begin
          case (bus.C_op)
            OP_NOP:  ;
            OP_UNLK: r_err <= E_NLOCK;
            OP_LOCK: begin
              r_key   <= bus.C_data;
              r_state <= S_LOCKED;
              r_err   <= E_NONE;
            end
            OP_BAL:  r_err <= w_sel_ok ? E_NONE : E_OP;
            OP_TMR:  begin r_timeout <= w_tmr_in;                    r_err <= E_NONE; end
            OP_COST: begin r_cost    <= bus.C_data;                  r_err <= E_NONE; end
            OP_MASK: begin r_mask    <= bus.C_data[NUM_BIDDERS-1:0]; r_err <= E_NONE; end
            default: r_err <= E_OP;
          endcase
          // A start request while unlocked is refused and reported.
          if (w_rise) r_err <= E_NLOCK;
        end
        S_LOCKED: begin
          if (w_rise) begin
            r_state   <= S_ACTIVE;
            r_ready   <= 1'b0;
            r_max_bid <= '0;
            r_win     <= '0;
            r_cur_max <= '0;
            r_lead    <= '0;
            r_timer   <= r_timeout;
          end else begin
            case (bus.C_op)
              OP_NOP:  ;
              OP_UNLK: begin
                if (bus.C_data == r_key) begin
                  r_state <= S_UNLOCKED;
                  r_err   <= E_NONE;
                end else begin
                  r_err   <= E_KEY;
                end
              end
              OP_LOCK, OP_BAL, OP_TMR, OP_COST, OP_MASK: r_err <= E_LOCKED;
              default: r_err <= E_OP;
            endcase
          end
        end
        S_ACTIVE: begin
          r_ack <= w_lead_oh;
          r_rej <= bus.bid_valid & ~w_lead_oh;
          if (w_new) begin
            r_cur_max <= w_best;
            r_lead    <= w_lead_oh;
          end
          // Controller release or timer expiry ends the round exactly once;
          // a new leader this cycle holds the timer off.
          if (!bus.C_start || (!w_new && r_timer <= TIMER_W'(1))) begin
            r_state      <= S_END;
            r_round_over <= 1'b1;
            r_max_bid    <= w_new ? w_best    : r_cur_max;
            r_win        <= w_new ? w_lead_oh : r_lead;
          end else if (w_new) begin
            r_timer <= r_timeout;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end
        S_END: begin
          r_state <= S_LOCKED;
          r_ready <= 1'b1;
        end
        default: r_state <= S_UNLOCKED;
      endcase
    end
  end

  assign bus.bid_ack    = r_ack;
  assign bus.bid_rej    = r_rej;
  assign bus.ready      = r_ready;
  assign bus.err        = r_err;
  assign bus.round_over = r_round_over;
  assign bus.max_bid    = r_max_bid;
  assign bus.win        = r_win;
  assign bus.win_count  = w_wcnt;
endmodule

// File: tb/tb_bidsn_auction.sv
// Scoreboard bench for bidsn_auction: expected ack/rej and round results are
// queued as stimulus is driven and checked when the engine reports them.
module tb_bidsn_auction;
  localparam int N  = 4;
  localparam int VW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bidsn_auction_if #(.NUM_BIDDERS(N), .VAL_W(VW)) bus ();

  bidsn_auction #(
    .NUM_BIDDERS(N), .VAL_W(VW), .TIMER_W(8), .DEFAULT_TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0]  q_bid[$];
  logic [19:0] q_rnd[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: pop an expectation whenever the engine pulses.
  always @(negedge clk) begin
    if (reset_n) begin
      if ((bus.bid_ack | bus.bid_rej) != '0) begin
        if (q_bid.size() == 0) chk("bid_unexpected", {bus.bid_ack, bus.bid_rej}, 8'h00);
        else                   chk("bid_ack_rej", {bus.bid_ack, bus.bid_rej}, q_bid.pop_front());
      end
      if (bus.round_over) begin
        if (q_rnd.size() == 0) chk("round_unexpected", {bus.win, bus.max_bid}, 20'h0);
        else                   chk("round_win_max", {bus.win, bus.max_bid}, q_rnd.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] o, input logic [15:0] d, input logic [1:0] s);
    bus.C_op = o; bus.C_data = d; bus.C_sel = s;
    tick();
    bus.C_op = 3'd0;
  endtask

  task automatic bid(input logic [3:0] v, input logic [15:0] v0, input logic [15:0] v1,
                     input logic [15:0] v2, input logic [15:0] v3,
                     input logic [3:0] ea, input logic [3:0] er);
    bus.bid_valid = v;
    bus.bid_val   = {v3, v2, v1, v0};
    q_bid.push_back({ea, er});
    tick();
    bus.bid_valid = '0;
  endtask

  task automatic start_round();
    bus.C_start = 1'b1;
    tick();
    chk("ready_in_round", bus.ready, 1'b0);
  endtask

  task automatic stop_round(input logic [3:0] w, input logic [15:0] m);
    q_rnd.push_back({w, m});
    bus.C_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_round(output int cyc);
    cyc = 0;
    while (!bus.round_over && cyc < 64) begin
      tick();
      cyc++;
    end
    if (!bus.round_over) chk("round_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    bus.C_op = 3'd0; bus.C_data = '0; bus.C_sel = '0; bus.C_start = 1'b0;
    bus.bid_valid = '0; bus.bid_val = '0;
    tick(); tick();
    // Reset state
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_outs", {bus.err, bus.round_over, bus.max_bid, bus.win, bus.bid_ack, bus.bid_rej}, 64'h0);
    chk("rst_wcnt", bus.win_count, 32'h0);
    reset_n = 1'b1;
    tick();

    // Config, lock, bad-key unlock
    op(3'd3, 16'd100, 2'd1);     chk("err_load", bus.err, 3'd0);
    op(3'd2, 16'hA5A5, 2'd0);    chk("err_lock", bus.err, 3'd0);
    op(3'd1, 16'h1234, 2'd0);    chk("err_badkey", bus.err, 3'd1);
    chk("ready_locked", bus.ready, 1'b1);
    op(3'd3, 16'd5, 2'd0);       chk("err_locked_op", bus.err, 3'd2);

    // Round 1: single bid, timer expiry after 16 idle cycles
    start_round();
    bid(4'b0010, 16'd0, 16'd40, 16'd0, 16'd0, 4'b0010, 4'b0000);
    q_rnd.push_back({4'b0010, 16'd40});
    wait_round(cyc);
    chk("idle_cycles_16", cyc, 16);
    tick();
    chk("ready_after_end", bus.ready, 1'b1);
    bus.C_start = 1'b0;
    tick();

    // Unlock and fund bidders
    op(3'd1, 16'hA5A5, 2'd0);    chk("err_unlock", bus.err, 3'd0);
    op(3'd3, 16'd200, 2'd0);
    op(3'd3, 16'd200, 2'd2);
    op(3'd3, 16'd90,  2'd3);
    op(3'd1, 16'h0000, 2'd0);    chk("err_not_locked", bus.err, 3'd3);
    op(3'd2, 16'h0BEE, 2'd0);    chk("err_relock", bus.err, 3'd0);

    // Round 2: tie goes to lowest index, underfunded and too-low bids rejected
    start_round();
    bid(4'b0101, 16'd50, 16'd0, 16'd50, 16'd0, 4'b0001, 4'b0100);
    bid(4'b1000, 16'd0,  16'd0, 16'd0,  16'd90, 4'b0000, 4'b1000);
    bid(4'b0010, 16'd0,  16'd20, 16'd0, 16'd0,  4'b0000, 4'b0010);
    stop_round(4'b0001, 16'd50);

    // Round 3: bidder1 holds exactly 59, bidder2 holds 199 after charges
    start_round();
    bid(4'b0010, 16'd0, 16'd59,  16'd0,   16'd0,  4'b0000, 4'b0010);
    bid(4'b0010, 16'd0, 16'd58,  16'd0,   16'd0,  4'b0010, 4'b0000);
    bid(4'b0100, 16'd0, 16'd0,   16'd198, 16'd0,  4'b0100, 4'b0000);
    bid(4'b0100, 16'd0, 16'd0,   16'd199, 16'd0,  4'b0000, 4'b0100);
    bid(4'b1000, 16'd0, 16'd0,   16'd0,   16'd89, 4'b0000, 4'b1000);
    stop_round(4'b0100, 16'd198);

    // Rounds 4 and 5: bidder3 wins
    for (int r = 0; r < 2; r++) begin
      start_round();
      bid(4'b1000, 16'd0, 16'd0, 16'd0, 16'd10, 4'b1000, 4'b0000);
      stop_round(4'b1000, 16'd10);
    end

    // Unlocked corner ops
    op(3'd1, 16'h0BEE, 2'd0);    chk("err_unlock2", bus.err, 3'd0);
    op(3'd4, 16'd0, 2'd0);       chk("err_set_timer0", bus.err, 3'd0);
    op(3'd7, 16'd0, 2'd0);       chk("err_bad_op", bus.err, 3'd4);
    op(3'd0, 16'd0, 2'd0);       chk("err_nop_keeps", bus.err, 3'd4);
    bus.C_start = 1'b1;
    tick();
    chk("err_start_unlocked", bus.err, 3'd3);
    chk("ready_unlocked", bus.ready, 1'b1);
    bus.C_start = 1'b0;
    tick();
    op(3'd2, 16'h0BEE, 2'd0);

    // Round 6: timeout of 0 behaves as 1
    start_round();
    bid(4'b1000, 16'd0, 16'd0, 16'd0, 16'd10, 4'b1000, 4'b0000);
    q_rnd.push_back({4'b1000, 16'd10});
    wait_round(cyc);
    chk("idle_cycles_1", cyc, 1);
    tick();
`ifdef BIDS_STATS_EN
    chk("win_count", bus.win_count, {8'd3, 8'd1, 8'd1, 8'd1});
`else
    chk("win_count", bus.win_count, 32'h0);
`endif
    chk("held_max_bid", bus.max_bid, 16'd10);
    bus.C_start = 1'b0;
    tick();

    // Round 7: reset mid-round clears outputs immediately
    start_round();
    bus.bid_valid = 4'b1000;
    bus.bid_val   = {16'd10, 16'd0, 16'd0, 16'd0};
    tick();
    bus.bid_valid = '0;
    reset_n = 1'b0;
    #1;
    chk("midrst_ack", {bus.bid_ack, bus.bid_rej}, 8'h00);
    chk("midrst_ready", bus.ready, 1'b1);
    chk("midrst_outs", {bus.err, bus.round_over, bus.max_bid, bus.win}, 64'h0);
    chk("midrst_wcnt", bus.win_count, 32'h0);
    bus.C_start = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    op(3'd1, 16'h0BEE, 2'd0);    chk("err_after_rst", bus.err, 3'd3);

    chk("q_bid_drained", q_bid.size(), 0);
    chk("q_rnd_drained", q_rnd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
